// File: rtl/test_arb_parallel_pkg.sv
// Shared types and constants for the parallel matrix-multiply block.
//   state_t : sequencing states (LOAD, COMPUTE, OUT, DONE)
//   ELEM_W  : width of one input matrix element
//   PROD_W  : width of one element product
//   RES_W   : width of one result element / accumulator
package test_arb_parallel_pkg;

   localparam int unsigned ELEM_W = 8;
   localparam int unsigned PROD_W = 2 * ELEM_W;
   localparam int unsigned RES_W  = 64;

   typedef enum logic [1:0] {
      LOAD    = 2'd0,
      COMPUTE = 2'd1,
      OUT     = 2'd2,
      DONE    = 2'd3
   } state_t;

endpackage

// File: rtl/test_arb_parallel_dot_product.sv
// Combinational unsigned dot product of one row and one column.
//   row   : LEN packed 8-bit elements, element 0 in the most-significant byte
//   col   : LEN packed 8-bit elements, same packing as row
//   sum_c : full-precision sum of the LEN element products
module dot_product
   import test_arb_parallel_pkg::*;
#(
   parameter int unsigned LEN = 5
) (
   input  logic [LEN*ELEM_W-1:0] row,
   input  logic [LEN*ELEM_W-1:0] col,
   output logic [RES_W-1:0]      sum_c
);

   logic [PROD_W-1:0] prod;

   // Multiply-accumulate across the vector; each product is 16 bits, sum is 64 bits.
   always_comb begin
      prod  = '0;
      sum_c = '0;
      for (int k = 0; k < int'(LEN); k++) begin
         prod  = PROD_W'(row[LEN*ELEM_W-1-ELEM_W*k -: ELEM_W]) *
                 PROD_W'(col[LEN*ELEM_W-1-ELEM_W*k -: ELEM_W]);
         sum_c = sum_c + RES_W'(prod);
      end
   end

endmodule

// File: rtl/test_arb_parallel.sv
// Parallel matrix multiplier R = A x B with serial row-major result readout.
// Operands are captured once after reset, every R(i,j) is computed in one
// cycle, then one element per cycle is presented on res until the block idles.
//   a   : matrix A, row-major, element (0,0) in the most-significant byte
//   b   : matrix B, same packing
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   res : bit 64 = element valid, bits 63:0 = element value (zero when idle)
module test_arb_parallel
   import test_arb_parallel_pkg::*;
#(
   parameter int unsigned aRow       = 5,
   parameter int unsigned aCol       = 5,
   parameter int unsigned bRow       = 5,
   parameter int unsigned bCol       = 5,
   parameter int unsigned matrixALen = aRow*aCol*8,
   parameter int unsigned matrixBLen = bRow*bCol*8,
   parameter int unsigned matrixRLen = aRow*bCol*8
) (
   input  logic [matrixALen-1:0] a,
   input  logic [matrixBLen-1:0] b,
   input  logic                  clk,
   input  logic                  rst,
   output logic [RES_W:0]        res
);

   // Result element count derived from the result-store size at 8 bits per element.
   localparam int unsigned NUM   = matrixRLen / ELEM_W;
   localparam int unsigned IDX_W = (NUM > 1) ? $clog2(NUM) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM - 1);

   state_t                state_q;
   state_t                state_d;
   logic [IDX_W-1:0]      idx_q;
   logic [IDX_W-1:0]      idx_d;
   logic [RES_W:0]        res_d;
   logic                  load_en;
   logic                  comp_en;
   logic [matrixALen-1:0] a_q;
   logic [matrixBLen-1:0] b_q;
   logic [RES_W-1:0]      r_q [NUM];
   logic [RES_W-1:0]      r_c [NUM];

   // One dot-product unit per result element; column j of B is gathered into a row-style vector.
   for (genvar gi = 0; gi < int'(aRow); gi++) begin : g_row
      for (genvar gj = 0; gj < int'(bCol); gj++) begin : g_col
         logic [aCol*ELEM_W-1:0] col_c;

         for (genvar gk = 0; gk < int'(bRow); gk++) begin : g_k
            assign col_c[aCol*ELEM_W-1-ELEM_W*gk -: ELEM_W] =
               b_q[matrixBLen-1-ELEM_W*(gk*bCol+gj) -: ELEM_W];
         end

         dot_product #(
            .LEN (aCol)
         ) u_dot (
            .row   (a_q[matrixALen-1-ELEM_W*gi*aCol -: aCol*ELEM_W]),
            .col   (col_c),
            .sum_c (r_c[gi*bCol+gj])
         );
      end
   end

   // Next-state, index and output decode.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      res_d   = '0;
      load_en = 1'b0;
      comp_en = 1'b0;
      case (state_q)
         LOAD: begin
            load_en = 1'b1;
            state_d = COMPUTE;
         end
         COMPUTE: begin
            comp_en = 1'b1;
            idx_d   = '0;
            state_d = OUT;
         end
         OUT: begin
            res_d = {1'b1, r_q[idx_q]};
            // Index saturates at the last element; the FSM leaves OUT instead of wrapping.
            if (idx_q == LAST_IDX) begin
               state_d = DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         DONE: begin
            state_d = DONE;
         end
         default: begin
            state_d = LOAD;
         end
      endcase
   end

   // State, operand, result-array and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= LOAD;
         idx_q   <= '0;
         res     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         for (int n = 0; n < int'(NUM); n++) begin
            r_q[n] <= '0;
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         res     <= res_d;
         if (load_en) begin
            a_q <= a;
            b_q <= b;
         end
         if (comp_en) begin
            for (int n = 0; n < int'(NUM); n++) begin
               r_q[n] <= r_c[n];
            end
         end
      end
   end

endmodule

// File: tb/tb_test_arb_parallel.sv
// Scoreboard bench for test_arb_parallel: a 5x5 instance driven with directed
// matrices and a 2x3 x 3x2 instance with a fixed hand-computed product.
module tb_test_arb_parallel;

   logic         clk;
   logic         rst;
   logic [199:0] a;
   logic [199:0] b;
   logic [64:0]  res;
   logic [47:0]  a2;
   logic [47:0]  b2;
   logic [64:0]  res2;

   typedef struct {
      int              at;
      longint unsigned val;
   } exp_t;

   exp_t        q[$];
   exp_t        q2[$];
   int unsigned ma [5][5];
   int unsigned mb [5][5];
   int          cnt;
   int          n_cmp;
   int          n_err;

   test_arb_parallel dut (
      .a   (a),
      .b   (b),
      .clk (clk),
      .rst (rst),
      .res (res)
   );

   test_arb_parallel #(
      .aRow (2),
      .aCol (3),
      .bRow (3),
      .bCol (2)
   ) dut_small (
      .a   (a2),
      .b   (b2),
      .clk (clk),
      .rst (rst),
      .res (res2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Rising edges since reset release.
   always @(posedge clk or posedge rst) begin
      if (rst) cnt <= 0;
      else     cnt <= cnt + 1;
   end

   task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (edge %0d, t=%0t)", name, act, exp, cnt, $time);
      end
   endtask

   // Monitor: pop an expected element when its edge arrives, else require an idle zero output.
   always @(negedge clk) begin
      if (rst) begin
         chk("rst_big", res, 65'd0);
         chk("rst_small", res2, 65'd0);
      end else begin
         if (q.size() > 0 && q[0].at == cnt) begin
            chk("elem_big", res, {1'b1, q[0].val});
            void'(q.pop_front());
         end else begin
            chk("idle_big", res, 65'd0);
         end
         if (q2.size() > 0 && q2[0].at == cnt) begin
            chk("elem_small", res2, {1'b1, q2[0].val});
            void'(q2.pop_front());
         end else begin
            chk("idle_small", res2, 65'd0);
         end
      end
   end

   task automatic pack_ab();
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 5; j++) begin
            a[199-8*(i*5+j) -: 8] = 8'(ma[i][j]);
            b[199-8*(i*5+j) -: 8] = 8'(mb[i][j]);
         end
   endtask

   task automatic push_exp();
      longint unsigned s;
      q.delete();
      q2.delete();
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 5; j++) begin
            s = 0;
            for (int k = 0; k < 5; k++) s += longint'(ma[i][k]) * longint'(mb[k][j]);
            q.push_back('{3 + i*5 + j, s});
         end
      q2.push_back('{3, 64'd58});
      q2.push_back('{4, 64'd64});
      q2.push_back('{5, 64'd139});
      q2.push_back('{6, 64'd154});
   endtask

   // With rst already high: apply operands, queue expectations, release.
   task automatic load_and_release();
      pack_ab();
      push_exp();
      @(posedge clk);
      #2 rst = 1'b0;
   endtask

   task automatic start_run();
      @(posedge clk);
      #2 rst = 1'b1;
      load_and_release();
   endtask

   task automatic finish_run(input string name);
      repeat (32) @(posedge clk);
      @(negedge clk);
      #1;
      chk({name, "_drain_big"}, 65'(q.size()), 65'd0);
      chk({name, "_drain_small"}, 65'(q2.size()), 65'd0);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst   = 1'b0;
      a     = '0;
      b     = '0;
      a2    = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
      b2    = {8'd7, 8'd8, 8'd9, 8'd10, 8'd11, 8'd12};
      #1 rst = 1'b1;

      // Rows [1..5] in both; later operand changes must be ignored.
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 5; j++) begin
            ma[i][j] = j + 1;
            mb[i][j] = j + 1;
         end
      load_and_release();
      @(posedge clk);
      #2;
      a = {25{8'hA5}};
      b = {25{8'h3C}};
      finish_run("rows");

      // Identity times arbitrary B.
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 5; j++) begin
            ma[i][j] = (i == j) ? 1 : 0;
            mb[i][j] = (i*37 + j*11 + 7) % 256;
         end
      start_run();
      finish_run("ident");

      // All 255: every element is 325125.
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 5; j++) begin
            ma[i][j] = 255;
            mb[i][j] = 255;
         end
      start_run();
      finish_run("max");

      // Zero A: 25 valid zeros.
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 5; j++) begin
            ma[i][j] = 0;
            mb[i][j] = i*5 + j + 100;
         end
      start_run();
      finish_run("zero");

      // Reset mid-OUT after element 7, then restart with fresh operands.
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 5; j++) begin
            ma[i][j] = j + 1;
            mb[i][j] = j + 1;
         end
      start_run();
      for (int t = 0; t < 20 && cnt < 10; t++) @(posedge clk);
      chk("reach_edge10", 65'(cnt), 65'd10);
      @(negedge clk);
      #1 rst = 1'b1;
      #1 chk("rst_async", res, 65'd0);
      for (int i = 0; i < 5; i++)
         for (int j = 0; j < 5; j++) mb[i][j] = i + 2*j + 1;
      load_and_release();
      finish_run("restart");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/test_arb_parallel.md
TEST_ARB_PARALLEL -- requirements
Module: test_arb_parallel

Interface
REQ-001 Parameters (name, default, meaning):
- aRow, 5, rows of matrix A
- aCol, 5, columns of A
- bRow, 5, rows of B; SHALL equal aCol
- bCol, 5, columns of B
- matrixALen, aRow*aCol*8, width of port a
- matrixBLen, bRow*bCol*8, width of port b
- matrixRLen, aRow*bCol*8, size in bits of the internal result store at 8 bits per element; sizing only, element registers themselves are 64 bits
REQ-002 Ports, in positional order a, b, clk, rst, res (name, direction, width, meaning):
- clk, in, 1, single clock; all state changes on rising edge
- rst, in, 1, reset; asynchronous, active-high
- a, in, matrixALen, matrix A, unsigned 8-bit elements
- b, in, matrixBLen, matrix B, unsigned 8-bit elements
- res, out, 65, bit 64 = valid, bits 63:0 = result element, zero-extended
REQ-003 Element packing for a and b: row-major, element (i,j) of A occupies bits [matrixALen-1-8*(i*aCol+j) -: 8], so element (0,0) is the most-significant byte; B is packed the same way.

Function
REQ-004 The block SHALL compute R = A x B, with R(i,j) = sum over k of A(i,k)*B(k,j), in full precision; the maximum value 255*255*aCol fits in 64 bits.
REQ-005 All aRow*bCol dot products SHALL be computed in parallel in a single COMPUTE cycle and registered into an internal result array.
REQ-006 FSM states and transitions:
- LOAD: register a and b, go to COMPUTE
- COMPUTE: register all R(i,j), clear the element index, go to OUT
- OUT: drive one element per cycle in row-major order; after the last element go to DONE
- DONE: hold, until reset
REQ-007 Timing: LOAD SHALL occur on the first rising edge after rst deasserts. Element k (k = i*bCol+j) SHALL appear on res with res[64]=1 after rising edge 3+k.
REQ-008 res[64] SHALL be 1 only in the cycle that presents a valid element; in all other cycles res SHALL be 65'b0.
REQ-009 Inputs a and b SHALL be sampled only in LOAD; later changes to a or b have no effect until the next reset.
REQ-010 Arithmetic SHALL be unsigned, with each product 16 bits and the accumulator 64 bits; no saturation occurs.
REQ-011 The element index SHALL be sized clog2(aRow*bCol) bits, minimum 1, and SHALL NOT wrap past the last element.

Reset
REQ-012 While rst=1: state SHALL be LOAD, res SHALL be 0, and the index, captured operands and result array SHALL be cleared, immediately and independent of clk.
REQ-013 Asserting rst during COMPUTE, OUT or DONE SHALL abort the sequence; after release the block restarts from LOAD with fresh inputs.

Structure
REQ-014 A shared package SHALL hold the state enum (LOAD, COMPUTE, OUT, DONE) and the constants ELEM_W=8 and RES_W=64.
REQ-015 One sub-module, dot_product, parameterised by length, SHALL compute a single R(i,j); it SHALL be instantiated aRow*bCol times by a generate loop.
REQ-016 The top-level SHALL contain the FSM, operand registers, result array and output mux.

Verification
REQ-017 5x5, every row of A and of B = [1,2,3,4,5] -> 25 valid outputs, each row reading 15,30,45,60,75, on edges 3..27; res=0 afterwards.
REQ-018 5x5, A = identity, B = any values -> outputs equal B elements in row-major order.
REQ-019 5x5, all elements 255 -> every output = 325125 (0x4F605), valid=1.
REQ-020 5x5, A or B all zero -> 25 outputs of 0 with valid=1 at the correct cycles.
REQ-021 rst asserted mid-OUT (after element 7) -> res=0 immediately; after release, a full 25-element sequence restarts from element 0.
REQ-022 aRow=2, aCol=bRow=3, bCol=2, A=[1,2,3;4,5,6], B=[7,8;9,10;11,12] -> outputs 58,64,139,154, then res=0.
